crack_ctrl: RTL and testbench

CRACK_CTRL -- requirements
Module: crack_ctrl

---
 rtl/crack_pkg.sv | 27 ++
 rtl/crack_ctrl_hex7seg.sv | 10 +
 rtl/crack_ctrl.sv | 134 +++++++++++++
 tb/tb_crack_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and constants for the key-cracking controller:
// FSM state encoding, segment patterns and the hex glyph table.
package crack_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PEND,
      LAUNCH,
      SEARCH,
      SHOW,
      FAIL
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Active-low glyphs for 0..F; index 0 is the leftmost entry
   localparam logic [0:15][6:0] SEG_GLYPH = {
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] glyph_of(input logic [3:0] nib);
      return SEG_GLYPH[nib];
   endfunction

endpackage

// File: rtl/crack_ctrl_hex7seg.sv
// Single-digit nibble to active-low 7-segment decoder.
module hex7seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   import crack_pkg::*;

   assign seg = glyph_of(nibble);

endmodule

// File: rtl/crack_ctrl.sv
// Controller for an external key-cracking engine: launches a search,
// times it, optionally aborts it on a cycle limit and shows the result
// on a row of 7-segment digits.
module crack_ctrl #(
   parameter int KEY_W       = 24,
   parameter int NUM_HEX     = KEY_W / 4,
   parameter int TIMEOUT_CYC = 0,
   parameter bit AUTO_START  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 en,
   input  logic                 rdy,
   input  logic [KEY_W-1:0]     key,
   input  logic                 key_valid,
   output logic [NUM_HEX*7-1:0] hex,
   output logic                 busy,
   output logic                 found,
   output logic                 timeout,
   output logic [31:0]          cycles
);
   import crack_pkg::*;

   localparam int          PAD_W   = (4 * NUM_HEX > KEY_W) ? 4 * NUM_HEX : KEY_W;
   localparam logic [31:0] CYC_MAX = 32'hFFFF_FFFF;
   localparam logic [31:0] LIMIT   = 32'(TIMEOUT_CYC);

   state_t               state;
   state_t               state_next;
   logic [KEY_W-1:0]     key_q;
   logic [KEY_W-1:0]     key_d;
   logic                 valid_d;
   logic                 rdy_ok;
   logic                 limit_hit;
   logic [31:0]          cnt_inc;
   logic [PAD_W-1:0]     key_pad;
   logic [NUM_HEX*7-1:0] glyph_all;
   logic [NUM_HEX*7-1:0] hex_d;
   logic                 busy_d;

   // Search qualifiers; the counter is cleared in LAUNCH, so a zero count
   // in SEARCH marks the first cycle, where the engine may still show rdy
   always_comb begin
      cnt_inc   = (cycles == CYC_MAX) ? cycles : cycles + 32'd1;
      rdy_ok    = (state == SEARCH) && (cycles != 32'd0) && rdy;
      limit_hit = (TIMEOUT_CYC > 0) && (state == SEARCH) && (cnt_inc >= LIMIT);
      key_d     = rdy_ok ? key : key_q;
      valid_d   = rdy_ok ? key_valid : found;
   end

   assign key_pad = PAD_W'(key_d);

   generate
      for (genvar i = 0; i < NUM_HEX; i++) begin : g_digit
         hex7seg u_digit (
            .nibble (key_pad[4*i +: 4]),
            .seg    (glyph_all[7*i +: 7])
         );
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; a captured result takes priority over the cycle limit
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (start || AUTO_START) state_next = PEND;
         PEND:      if (rdy) state_next = LAUNCH;
         LAUNCH:    state_next = SEARCH;
         SEARCH: begin
            if (rdy_ok)         state_next = SHOW;
            else if (limit_hit) state_next = FAIL;
         end
         SHOW, FAIL: if (start) state_next = PEND;
         default:   state_next = IDLE;
      endcase
   end

   // Outputs: launch pulse from state, next values for the registered outputs
   always_comb begin
      en     = (state == LAUNCH);
      busy_d = (state_next == PEND) || (state_next == LAUNCH) || (state_next == SEARCH);
      case (state_next)
         SHOW:    hex_d = valid_d ? glyph_all : {NUM_HEX{SEG_DASH}};
         FAIL:    hex_d = {NUM_HEX{SEG_DASH}};
         default: hex_d = {NUM_HEX{SEG_BLANK}};
      endcase
   end

   // Result registers: counter, captured key and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         hex     <= {NUM_HEX{SEG_BLANK}};
         found   <= 1'b0;
         timeout <= 1'b0;
         cycles  <= 32'd0;
         key_q   <= '0;
      end else begin
         busy <= busy_d;
         hex  <= hex_d;
         case (state)
            LAUNCH: begin
               cycles  <= 32'd0;
               found   <= 1'b0;
               timeout <= 1'b0;
            end
            SEARCH: begin
               cycles <= cnt_inc;
               if (rdy_ok) begin
                  key_q <= key;
                  found <= key_valid;
               end else if (limit_hit) begin
                  timeout <= 1'b1;
               end
            end
            SHOW, FAIL: begin
               if (start) begin
                  found   <= 1'b0;
                  timeout <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crack_ctrl.sv
// Randomised scoreboard bench for crack_ctrl: the stimulus side plays the
// cracking engine and queues the expected result of each search; a monitor
// compares the result whenever busy falls.
module tb_crack_ctrl;

   localparam int KW = 24;
   localparam int NH = 6;
   localparam int T  = 120;
   localparam logic [NH*7-1:0] BLANK_ALL = {NH{7'h7F}};
   localparam logic [NH*7-1:0] DASH_ALL  = {NH{7'h3F}};

   typedef struct {
      logic            found;
      logic            tmo;
      logic [31:0]     cyc;
      logic [NH*7-1:0] hex;
   } exp_t;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            start     = 1'b0;
   logic            rdy       = 1'b1;
   logic            key_valid = 1'b0;
   logic [KW-1:0]   key       = '0;
   logic            en;
   logic            busy;
   logic            found;
   logic            timeout;
   logic [31:0]     cycles;
   logic [NH*7-1:0] hex;

   int   vectors     = 0;
   int   miscompares = 0;
   int   en_count    = 0;
   logic busy_prev   = 1'b0;
   exp_t exp_q[$];

   crack_ctrl #(
      .KEY_W       (KW),
      .NUM_HEX     (NH),
      .TIMEOUT_CYC (T),
      .AUTO_START  (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .key_valid (key_valid),
      .hex       (hex),
      .busy      (busy),
      .found     (found),
      .timeout   (timeout),
      .cycles    (cycles)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Hard stop in case something wedges
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // Active-low glyph of one hex nibble
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
         default: return 7'h7F;
      endcase
   endfunction

   // Reference result: the engine keeps rdy low for d cycles after launch.
   // The search lasts d+1 cycles but never fewer than 2, since rdy on the
   // first search cycle is ignored; a search longer than T is cut at T.
   function automatic exp_t modelResult(input int d, input logic [KW-1:0] k, input logic v);
      exp_t r;
      int   n;
      n = (d + 1 < 2) ? 2 : d + 1;
      if (T > 0 && n > T) begin
         r.found = 1'b0;
         r.tmo   = 1'b1;
         r.cyc   = 32'(T);
         r.hex   = DASH_ALL;
      end else begin
         r.found = v;
         r.tmo   = 1'b0;
         r.cyc   = 32'(n);
         r.hex   = DASH_ALL;
         if (v) for (int i = 0; i < NH; i++) r.hex[7*i +: 7] = seg_of(k[4*i +: 4]);
      end
      return r;
   endfunction

   // Monitor: count launch pulses and score each finished search
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         busy_prev = 1'b0;
      end else begin
         if (en) en_count++;
         if (busy_prev && !busy) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_result", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("found",   64'(found),   64'(e.found));
               checkOutput("timeout", 64'(timeout), 64'(e.tmo));
               checkOutput("cycles",  64'(cycles),  64'(e.cyc));
               checkOutput("hex",     64'(hex),     64'(e.hex));
            end
         end
         busy_prev = busy;
      end
   end

   task automatic checkReset(input string tag);
      checkOutput({tag, "_en"},      64'(en),      64'd0);
      checkOutput({tag, "_busy"},    64'(busy),    64'd0);
      checkOutput({tag, "_found"},   64'(found),   64'd0);
      checkOutput({tag, "_timeout"}, 64'(timeout), 64'd0);
      checkOutput({tag, "_cycles"},  64'(cycles),  64'd0);
      checkOutput({tag, "_hex"},     64'(hex),     64'(BLANK_ALL));
   endtask

   task automatic waitEn();
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (en) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("en_launch", 64'(got), 64'd1);
   endtask

   // Pulse start from SHOW/FAIL; flags clear and a new launch follows
   task automatic relaunch();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("relaunch_found",   64'(found),   64'd0);
      checkOutput("relaunch_timeout", 64'(timeout), 64'd0);
      checkOutput("relaunch_busy",    64'(busy),    64'd1);
      waitEn();
   endtask

   // Play the engine for one search; entered at the negedge of the launch cycle
   task automatic applyStimulus(input int d, input logic [KW-1:0] k, input logic v, input logic mid);
      int   en_before;
      logic done;
      exp_q.push_back(modelResult(d, k, v));
      checkOutput("hex_blank_launch", 64'(hex), 64'(BLANK_ALL));
      @(posedge clk); #1;
      en_before = en_count;
      for (int i = 0; i < d; i++) begin
         rdy       = 1'b0;
         key       = KW'($urandom);
         key_valid = 1'($urandom);
         start     = mid && (i == d / 2);
         @(posedge clk); #1;
      end
      start     = 1'b0;
      rdy       = 1'b1;
      key       = k;
      key_valid = v;
      done = 1'b0;
      for (int j = 0; j < 300; j++) begin
         if (!busy) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("search_done", 64'(done), 64'd1);
      checkOutput("no_extra_en", 64'(en_count), 64'(en_before));
   endtask

   initial begin
      int snap;
      $display("[TB] crack_ctrl bench start");
      #12;
      checkReset("reset");

      // Auto-start: en in the third cycle after reset release
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("en_cycle2", 64'(en), 64'd0);
      checkOutput("busy_pend", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("en_cycle3", 64'(en), 64'd1);
      applyStimulus(100, 24'h1A2B3C, 1'b1, 1'b1);

      relaunch();
      applyStimulus(100, 24'h1A2B3C, 1'b0, 1'b0);

      // Limit boundary: rdy on the last allowed cycle wins, one later times out
      relaunch();
      applyStimulus(T - 1, KW'($urandom), 1'b1, 1'b1);
      relaunch();
      applyStimulus(T, KW'($urandom), 1'b1, 1'b0);

      // rdy held low well past the limit, then idle engine while in FAIL
      relaunch();
      applyStimulus(200, KW'($urandom), 1'b1, 1'b0);
      snap = en_count;
      repeat (10) @(negedge clk);
      checkOutput("fail_no_relaunch", 64'(en_count), 64'(snap));
      checkOutput("fail_busy", 64'(busy), 64'd0);

      // Engine that never drops rdy
      relaunch();
      applyStimulus(0, KW'($urandom), 1'b1, 1'b0);

      // Reset in the middle of a search
      relaunch();
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         rdy = 1'b0;
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkReset("midreset");
      rdy = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reen_cycle2", 64'(en), 64'd0);
      @(negedge clk);
      checkOutput("reen_cycle3", 64'(en), 64'd1);
      applyStimulus(int'($urandom_range(130, 0)), KW'($urandom), 1'($urandom), 1'b1);

      // Random searches
      for (int n = 0; n < 10; n++) begin
         relaunch();
         applyStimulus(int'($urandom_range(130, 0)), KW'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
